weight_load_sched: RTL and testbench

- Sequences weight-tile loads into the weight FIFO and hands each loaded tile to the weight FIFO controller.
- Accepts tile commands (base address, stagger flag) into a 2-entry queue.
- For each tile: reads FIFO_DEPTH rows from weight memory, pushes them into the FIFO, pulses the controller's `active` input, then waits for its `done`.
- Sits between the instruction decoder and the weight FIFO / FIFO controller pair.

---
 rtl/weight_load_sched_if.sv | 31 +++
 rtl/weight_load_sched.sv | 130 +++++++++++++
 tb/tb_weight_load_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/weight_load_sched_if.sv
// Handshake and datapath bundle between the weight-load scheduler, the command
// source, the weight memory, and the weight FIFO / FIFO controller pair.
interface weight_load_sched_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  cmd_stagger;
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;
    logic                  fifo_wr_en;
    logic [DATA_WIDTH-1:0] fifo_wr_data;
    logic                  ctrl_active;
    logic                  ctrl_stagger;
    logic                  ctrl_done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_stagger, mem_rd_data, ctrl_done,
        output cmd_ready, mem_rd_en, mem_rd_addr, fifo_wr_en, fifo_wr_data,
               ctrl_active, ctrl_stagger
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_stagger, mem_rd_data, ctrl_done,
        input  cmd_ready, mem_rd_en, mem_rd_addr, fifo_wr_en, fifo_wr_data,
               ctrl_active, ctrl_stagger
    );
endinterface

// File: rtl/weight_load_sched.sv
// Weight-tile load scheduler: queues tile commands, streams FIFO_DEPTH rows from
// weight memory into the weight FIFO, then hands the tile to the FIFO controller.
module weight_load_sched #(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    weight_load_sched_if.master  bus,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] tiles_done
);
    localparam int ROW_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(FIFO_DEPTH - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] FETCH     = 3'd1;
    localparam logic [2:0] DRAIN     = 3'd2;
    localparam logic [2:0] HANDOFF   = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;

    logic [2:0]            state;
    logic [ROW_W-1:0]      row;
    logic                  guard;
    logic [ADDR_WIDTH-1:0] tile_addr;
    logic                  tile_stagger;

    logic [ADDR_WIDTH-1:0] q_addr [2];
    logic                  q_stag [2];
    logic                  wptr;
    logic                  rptr;
    logic [1:0]            q_cnt;
    logic                  q_empty;
    logic                  q_full;
    logic                  push;
    logic                  pop;
    logic                  done_now;
    logic                  fetch;

    logic                  vld_p1;
    logic [DATA_WIDTH-1:0] wr_data;

    // The controller's done is only trusted once it has had a cycle to latch `started`.
    assign done_now = (state == WAIT_DONE) && !guard && bus.ctrl_done;
    assign q_empty  = (q_cnt == 2'd0);
    assign q_full   = (q_cnt == 2'd2);
    // A finishing tile pops the next command directly so FETCH follows immediately.
    assign pop      = !q_empty && ((state == IDLE) || done_now);
    assign bus.cmd_ready = !q_full || pop;
    assign push     = bus.cmd_valid && bus.cmd_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            q_cnt <= 2'd0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            q_cnt <= q_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wptr] <= bus.cmd_addr;
            q_stag[wptr] <= bus.cmd_stagger;
        end
        if (pop) begin
            tile_addr    <= q_addr[rptr];
            tile_stagger <= q_stag[rptr];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            row        <= '0;
            guard      <= 1'b0;
            tiles_done <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        row   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    row <= row + 1'b1;
                    if (row == LAST_ROW) state <= DRAIN;
                end
                DRAIN:   state <= HANDOFF;
                HANDOFF: begin
                    guard <= 1'b1;
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    guard <= 1'b0;
                    if (done_now) begin
                        tiles_done <= tiles_done + 1'b1;
                        row        <= '0;
                        state      <= pop ? FETCH : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign fetch           = (state == FETCH);
    assign bus.mem_rd_en   = fetch;
    assign bus.mem_rd_addr = fetch ? (tile_addr + ADDR_WIDTH'(row)) : '0;

    // p0 -> p1: read strobe follows the memory's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (reset) vld_p1 <= 1'b0;
        else       vld_p1 <= fetch;
    end

    assign wr_data          = vld_p1 ? bus.mem_rd_data : '0;
    assign bus.fifo_wr_en   = vld_p1;
    assign bus.fifo_wr_data = wr_data;

    assign bus.ctrl_active  = (state == HANDOFF);
    assign bus.ctrl_stagger = (state == HANDOFF) && tile_stagger;
    assign busy             = (state != IDLE) || !q_empty;
endmodule

// File: tb/tb_weight_load_sched.sv
// Self-checking bench for weight_load_sched: memory and FIFO-controller models,
// a read/write/handoff scoreboard, a tile vector table and corner-case sequences.
module tb_weight_load_sched;
    localparam int AW    = 16;
    localparam int DW    = 128;
    localparam int CW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          busy;
    logic [CW-1:0] tiles_done;

    weight_load_sched_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    weight_load_sched #(
        .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .busy(busy), .tiles_done(tiles_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [AW-1:0] exp_addr [$];
    logic [DW-1:0] exp_data [$];
    logic          exp_stag [$];
    int            run_len = 0;
    int            ctrl_left = 0;
    logic          prev_rd = 1'b0;
    logic [AW-1:0] mon_ea;
    logic [DW-1:0] mon_ed;
    logic          mon_es;

    typedef struct {
        logic [AW-1:0] addr;
        logic          stag;
        int            run;
        logic [CW-1:0] exp_tiles;
    } vec_t;
    vec_t vecs [4];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {4{a ^ 16'h5A5A, ~a}};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Synchronous weight memory: data for the address strobed in one cycle appears in the next.
    always @(posedge clk)
        bus.mem_rd_data <= bus.mem_rd_en ? mem_word(bus.mem_rd_addr) : {4{32'hDEADBEEF}};

    // FIFO controller: done drops for run_len cycles after each active pulse.
    always @(posedge clk) begin
        if (reset) begin
            bus.ctrl_done <= 1'b1;
            ctrl_left     <= 0;
        end else if (bus.ctrl_active) begin
            ctrl_left     <= run_len;
            bus.ctrl_done <= (run_len == 0);
        end else if (ctrl_left > 1) begin
            ctrl_left <= ctrl_left - 1;
        end else if (ctrl_left == 1) begin
            ctrl_left     <= 0;
            bus.ctrl_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            prev_rd <= 1'b0;
        end else begin
            check("wr_en_follows_rd", DW'(bus.fifo_wr_en), DW'(prev_rd));
            if (!bus.ctrl_done)
                check("no_rd_while_ctrl_busy", DW'(bus.mem_rd_en), DW'(0));
            if (bus.mem_rd_en) begin
                check("rd_expected", DW'(exp_addr.size() != 0), DW'(1));
                if (exp_addr.size() != 0) begin
                    mon_ea = exp_addr.pop_front();
                    check("rd_addr", DW'(bus.mem_rd_addr), DW'(mon_ea));
                    exp_data.push_back(mem_word(mon_ea));
                end
            end
            if (bus.fifo_wr_en) begin
                check("wr_expected", DW'(exp_data.size() != 0), DW'(1));
                if (exp_data.size() != 0) begin
                    mon_ed = exp_data.pop_front();
                    check("wr_data", bus.fifo_wr_data, mon_ed);
                end
            end
            if (bus.ctrl_active) begin
                check("active_expected", DW'(exp_stag.size() != 0), DW'(1));
                if (exp_stag.size() != 0) begin
                    mon_es = exp_stag.pop_front();
                    check("ctrl_stagger", DW'(bus.ctrl_stagger), DW'(mon_es));
                end
                check("active_after_last_wr", DW'(bus.fifo_wr_en), DW'(0));
                check("active_with_done_high", DW'(bus.ctrl_done), DW'(1));
                check("active_reads_drained", DW'(exp_addr.size() % DEPTH), DW'(0));
            end
            prev_rd <= bus.mem_rd_en;
        end
    end

    task automatic send(input logic [AW-1:0] a, input logic s, output int waited);
        waited = 0;
        bus.cmd_valid   = 1'b1;
        bus.cmd_addr    = a;
        bus.cmd_stagger = s;
        while (!bus.cmd_ready && waited < 2000) begin
            tick();
            waited++;
        end
        check("cmd_accept", DW'(bus.cmd_ready), DW'(1));
        for (int r = 0; r < DEPTH; r++) exp_addr.push_back(a + AW'(r));
        exp_stag.push_back(s);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || !bus.ctrl_done) && n < 3000) begin
            tick();
            n++;
        end
        check("idle_reached", DW'(busy), DW'(0));
        check("scoreboard_drained", DW'(exp_addr.size() + exp_data.size() + exp_stag.size()), DW'(0));
    endtask

    initial begin
        int w;
        int n;
        int k;
        bus.cmd_valid   = 1'b0;
        bus.cmd_addr    = '0;
        bus.cmd_stagger = 1'b0;

        vecs[0] = '{16'h0100, 1'b0, 5, 8'd1};
        vecs[1] = '{16'hFFF8, 1'b1, 0, 8'd2};
        vecs[2] = '{16'h1234, 1'b0, 1, 8'd3};
        vecs[3] = '{16'h0000, 1'b1, 3, 8'd4};

        repeat (3) tick();
        check("rst_cmd_ready",    DW'(bus.cmd_ready),    DW'(1));
        check("rst_mem_rd_en",    DW'(bus.mem_rd_en),    DW'(0));
        check("rst_mem_rd_addr",  DW'(bus.mem_rd_addr),  DW'(0));
        check("rst_fifo_wr_en",   DW'(bus.fifo_wr_en),   DW'(0));
        check("rst_fifo_wr_data", bus.fifo_wr_data,      DW'(0));
        check("rst_ctrl_active",  DW'(bus.ctrl_active),  DW'(0));
        check("rst_ctrl_stagger", DW'(bus.ctrl_stagger), DW'(0));
        check("rst_busy",         DW'(busy),             DW'(0));
        check("rst_tiles_done",   DW'(tiles_done),       DW'(0));
        reset = 1'b0;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_len = vecs[i].run;
            send(vecs[i].addr, vecs[i].stag, w);
            wait_idle();
            check("vec_tiles_done", DW'(tiles_done), DW'(vecs[i].exp_tiles));
        end

        // Queue fills while tile 0 fetches; the third command needs a pop.
        run_len = 2;
        send(16'h2000, 1'b0, w);
        n = 0;
        while (!bus.mem_rd_en && n < 50) begin tick(); n++; end
        check("q_t0_fetching", DW'(bus.mem_rd_en), DW'(1));
        send(16'h3000, 1'b1, w);
        send(16'h4000, 1'b0, w);
        check("q_ready_low_full", DW'(bus.cmd_ready), DW'(0));
        send(16'h5000, 1'b1, w);
        check("q_third_waited", DW'(w > 0), DW'(1));
        wait_idle();
        check("q_tiles_done", DW'(tiles_done), DW'(8));

        // Slow controller with the next tile already queued.
        run_len = 40;
        send(16'h6000, 1'b0, w);
        send(16'h7000, 1'b1, w);
        n = 0;
        while (!bus.ctrl_active && n < 100) begin tick(); n++; end
        check("slow_active_seen", DW'(bus.ctrl_active), DW'(1));
        tick();
        k = 1;
        while (!bus.ctrl_done && k < 200) begin tick(); k++; end
        check("slow_done_low_span", DW'(k), DW'(41));
        tick();
        check("slow_next_rd_en",   DW'(bus.mem_rd_en),   DW'(1));
        check("slow_next_rd_addr", DW'(bus.mem_rd_addr), DW'(16'h7000));
        wait_idle();
        check("slow_tiles_done", DW'(tiles_done), DW'(10));

        // Reset while fetching row 7.
        run_len = 0;
        send(16'h0500, 1'b1, w);
        n = 0;
        while (!(bus.mem_rd_en && bus.mem_rd_addr == 16'h0507) && n < 50) begin tick(); n++; end
        check("mid_row7_reached", DW'(bus.mem_rd_addr), DW'(16'h0507));
        reset = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        exp_stag.delete();
        tick();
        check("mid_rst_rd_en",     DW'(bus.mem_rd_en),   DW'(0));
        check("mid_rst_wr_en",     DW'(bus.fifo_wr_en),  DW'(0));
        check("mid_rst_active",    DW'(bus.ctrl_active), DW'(0));
        check("mid_rst_cmd_ready", DW'(bus.cmd_ready),   DW'(1));
        check("mid_rst_tiles",     DW'(tiles_done),      DW'(0));
        reset = 1'b0;
        repeat (10) begin
            tick();
            check("mid_quiet_rd_en", DW'(bus.mem_rd_en), DW'(0));
        end
        check("mid_quiet_busy", DW'(busy), DW'(0));

        // Counter wrap over 256 tiles.
        run_len = 0;
        for (int i = 0; i < 255; i++) send(AW'(i * 16), i[0], w);
        wait_idle();
        check("wrap_tiles_255", DW'(tiles_done), DW'(255));
        send(16'hABC0, 1'b1, w);
        wait_idle();
        check("wrap_tiles_0", DW'(tiles_done), DW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
